// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier controller: state
// encodings, ALU function-select constants and datapath status field positions.
package booth_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] EVAL  = 3'd2;
  localparam logic [2:0] ADD   = 3'd3;
  localparam logic [2:0] SHIFT = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  // funsel bits: [2] select A, [1] select 2A, [0] negate
  localparam logic [2:0] FS_ZERO = 3'b000;
  localparam logic [2:0] FS_PA   = 3'b100;
  localparam logic [2:0] FS_P2A  = 3'b010;
  localparam logic [2:0] FS_M2A  = 3'b011;
  localparam logic [2:0] FS_MA   = 3'b101;

  localparam int ST_X_LSB   = 0;
  localparam int ST_X_MSB   = 2;
  localparam int ST_CNT_LSB = 3;

  typedef struct packed {
    logic dpinit;
    logic ald;
    logic pld;
    logic xld;
    logic cntld;
    logic control;
    logic busy;
    logic done;
  } ctrl_t;

  function automatic logic is_zero_digit(input logic [2:0] x);
    return (x == 3'b000) || (x == 3'b111);
  endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: maps the triplet {b(i+1), b(i), b(i-1)} onto the
// ALU function select.
module booth_recode
  import booth_pkg::*;
(
  input  logic [2:0] x,
  output logic [2:0] funsel
);

  always_comb begin
    funsel = FS_ZERO;
    case (x)
      3'b001, 3'b010: funsel = FS_PA;
      3'b011:         funsel = FS_P2A;
      3'b100:         funsel = FS_M2A;
      3'b101, 3'b110: funsel = FS_MA;
      default:        funsel = FS_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_ctrl.sv
// Control FSM for the radix-4 Booth multiplier datapath (signed 8x8 -> 16).
// Define BOOTH_SKIP_ZERO_EN to bypass the ADD cycle for zero Booth digits.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int ITERS = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W+2:0] status,
  output logic             dpinit,
  output logic             ald,
  output logic             pld,
  output logic             xld,
  output logic             cntld,
  output logic             control,
  output logic [2:0]       funsel,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       x;
  logic [2:0]       recode_fs;
  ctrl_t            ctrl;

  assign cnt = status[CNT_W+ST_CNT_LSB-1:ST_CNT_LSB];
  assign x   = status[ST_X_MSB:ST_X_LSB];

  booth_recode u_recode (
    .x      (x),
    .funsel (recode_fs)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD:  state_nx = EVAL;
      EVAL: begin
        // cnt beyond ITERS is illegal; finishing keeps the FSM from hanging
        if (cnt >= ITERS_C) state_nx = DONE;
`ifdef BOOTH_SKIP_ZERO_EN
        else if (is_zero_digit(x)) state_nx = SHIFT;
`endif
        else state_nx = ADD;
      end
      ADD:   state_nx = SHIFT;
      SHIFT: state_nx = EVAL;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      LOAD: begin
        ctrl.dpinit = 1'b1;
        ctrl.ald    = 1'b1;
        ctrl.busy   = 1'b1;
      end
      EVAL: ctrl.busy = 1'b1;
      ADD: begin
        ctrl.pld  = 1'b1;
        ctrl.busy = 1'b1;
      end
      SHIFT: begin
        ctrl.pld     = 1'b1;
        ctrl.control = 1'b1;
        ctrl.xld     = 1'b1;
        ctrl.cntld   = 1'b1;
        ctrl.busy    = 1'b1;
      end
      DONE: ctrl.done = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign dpinit  = ctrl.dpinit;
  assign ald     = ctrl.ald;
  assign pld     = ctrl.pld;
  assign xld     = ctrl.xld;
  assign cntld   = ctrl.cntld;
  assign control = ctrl.control;
  assign busy    = ctrl.busy;
  assign done    = ctrl.done;
  // funsel is the only output that follows status combinationally
  assign funsel  = (state == ADD) ? recode_fs : FS_ZERO;

endmodule

// File: doc/booth_ctrl.md
Name: booth_ctrl

Overview:
- Control FSM for the radix-4 Booth multiplier datapath. It sits directly upstream of the datapath.
- Consumes the datapath's 6-bit status (iteration count and Booth triplet).
- Drives every datapath load enable, the ALU function select, the shift/add mux select, and the datapath init strobe.
- Gives the system a start/busy/done handshake for one signed 8x8 -> 16 multiply.

Parameters:
- ITERS, 4: number of add/shift iterations (multiplier width / 2).
- CNT_W, 3: width of the count field in status; ITERS must be < 2**CNT_W.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- status  input  6  from datapath: [5:3] = cnt, [2:0] = Booth triplet x = {b(i+1), b(i), b(i-1)}.
- dpinit  output  1  datapath init strobe (datapath reset pin): loads p, a and x, clears cnt.
- ald  output  1  multiplicand register load enable.
- pld  output  1  product register load enable.
- xld  output  1  triplet register load enable.
- cntld  output  1  iteration counter increment enable.
- control  output  1  product mux select: 0 = ALU sum, 1 = arithmetic shift right by 2.
- funsel  output  3  ALU select: [2] = select A, [1] = select 2A, [0] = negate (invert plus carry-in).
- busy  output  1  high from LOAD through the final EVAL.
- done  output  1  one-cycle pulse; product valid in datapath p.

Behaviour:
- Reset: state = IDLE; all outputs 0. Reset asserted mid-operation aborts on the next edge; no done pulse is issued.
- Outputs are Moore-decoded from registered state. The exception is funsel, which is combinational from status[2:0] during ADD.
- IDLE: all outputs 0. On start = 1, go to LOAD.
- LOAD (1 cycle): dpinit = 1, ald = 1, busy = 1. Next state is EVAL.
- EVAL (1 cycle): busy = 1, no enables.
  - If status[5:3] == ITERS, go to DONE.
  - Otherwise go to ADD.
- ADD (1 cycle): pld = 1, control = 0, funsel = recode(x).
- SHIFT (1 cycle): pld = 1, control = 1, xld = 1, cntld = 1. Next state is EVAL; the incremented cnt is visible in EVAL.
- DONE (1 cycle): done = 1, busy = 0. Next state is IDLE.
- Booth recode of x to funsel:
  - 000 and 111 (zero): 000
  - 001 and 010 (+A): 100
  - 011 (+2A): 010
  - 100 (-2A): 011
  - 101 and 110 (-A): 101
- Latency with ITERS = 4 (start sampled at edge 0):
  - LOAD in cycle 1.
  - Iterations in cycles 2-13.
  - Final EVAL in cycle 14.
  - done in cycle 15.
- A new start is accepted in the cycle after DONE.
- start is ignored in every state except IDLE; holding start high gives back-to-back multiplies.
- In ADD and SHIFT, funsel, xld and cntld are never asserted outside the rows above.
- Status values with cnt > ITERS (illegal) are treated as ITERS and go to DONE, so the FSM cannot hang.

Optional Feature:
- Macro: BOOTH_SKIP_ZERO_EN.
- Defined: in EVAL, when cnt != ITERS and x is 000 or 111, go directly to SHIFT and skip ADD. This saves one cycle per zero digit.
  - Multiplier 0: done in cycle 11.
  - Multiplier -1 (0xFF, triplets 110 then 111,111,111): 1 ADD only, done in cycle 12.
- Undefined: ADD is always executed, with funsel = 000 for zero digits. Latency is fixed at 15 cycles.

Decomposition:
- Package booth_pkg holds:
  - state encodings (IDLE, LOAD, EVAL, ADD, SHIFT, DONE; 3-bit binary).
  - funsel constants (FS_ZERO, FS_PA, FS_P2A, FS_M2A, FS_MA).
  - status field bit positions.
- One sub-module, booth_recode: combinational 3-bit x -> 3-bit funsel, unit-testable on its own.

Test Plan:
- Recode sweep: hold state in ADD via the bench model and drive x = 000..111 -> funsel = 000, 100, 100, 010, 011, 101, 101, 000.
- Full multiply with a behavioural datapath model: a = 7, p = -3 (0xFD) -> done in cycle 15, p = 0xFFEB (-21); pld asserted exactly 8 times, cntld 4 times.
- Extremes: -128 x -128 -> p = 0x4000; 127 x -128 -> p = 0xC080; each with done exactly one cycle wide and busy low in the DONE cycle.
- Reset at cycle 7 of a multiply -> all outputs 0 on the next edge, no done pulse. A fresh start then yields done 15 cycles later.
- start held high for 40 cycles -> exactly 2 complete multiplies, done in cycles 15 and 31; start pulses during busy are ignored.
- With BOOTH_SKIP_ZERO_EN: multiplier 0 -> done in cycle 11, zero ADD cycles. Without the macro, the same stimulus -> done in cycle 15.
